// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch port and the load/store port; one access per 3 cycles.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              stall,
  output logic [15:0]       conflicts
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_next;
  logic              gnt, gnt_next;
  logic              last_grant, last_grant_next;
  logic              we_l, we_next;
  logic [ADDR_W-1:0] addr_l, addr_next;
  logic [DATA_W-1:0] wdata_l, wdata_next;
  logic              conflict_hit;
  logic              pick_d;

  // Grant goes to D when it is alone, or when both ask and IF won last time.
  assign pick_d = d_req & (~if_req | ~last_grant);

  always_comb begin
    state_next      = state;
    gnt_next        = gnt;
    last_grant_next = last_grant;
    we_next         = we_l;
    addr_next       = addr_l;
    wdata_next      = wdata_l;
    conflict_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (if_req | d_req) begin
          gnt_next        = pick_d;
          last_grant_next = pick_d;
          we_next         = pick_d & d_we;
          addr_next       = pick_d ? d_addr : if_addr;
          wdata_next      = d_wdata;
          conflict_hit    = if_req & d_req;
          state_next      = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b0;
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      conflicts  <= '0;
    end else begin
      state      <= state_next;
      gnt        <= gnt_next;
      last_grant <= last_grant_next;
      we_l       <= we_next;
      addr_l     <= addr_next;
      wdata_l    <= wdata_next;
      if (conflict_hit && (conflicts != '1))
        conflicts <= conflicts + 16'd1;
    end
  end

  assign mem_addr = addr_l;
  assign mem_wd   = wdata_l;
  assign mem_re   = (state == ACCESS) & ~we_l;
  assign mem_we   = (state == ACCESS) & we_l;

  assign if_valid = (state == RESP) & ~gnt;
  assign d_valid  = (state == RESP) & gnt;
  assign if_rdata = mem_rd;
  assign d_rdata  = mem_rd;

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// requesters, compared against a transaction-level model with its own RAM copy.
module tb_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd = '0;
  logic              stall;
  logic [15:0]       conflicts;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .stall(stall), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i == 4) ? 32'h00500093 : (i * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // Word-organised RAM behind the arbiter, registered read.
  logic [31:0] ram [0:255];
  logic        ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int unsigned i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wd;
      if (mem_re) mem_rd <= ram[mem_addr[9:2]];
    end
  end

  // Reference model: cycles remaining in the current access plus its details.
  int unsigned m_left = 0;
  logic        m_lg = 1'b0, m_d = 1'b0, m_we = 1'b0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_wd = '0;
  logic [15:0] m_conf = '0;
  logic [31:0] ref_mem [0:255];
  logic        e_if_valid = 1'b0, e_d_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (m_left == 2 && m_we) ref_mem[m_addr[9:2]] = m_wd;
    if (reset) begin
      m_left = 0; m_lg = 1'b0; m_conf = '0;
      m_d = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
    end else if (m_left == 0) begin
      if (if_req || d_req) begin
        m_d = d_req && (!if_req || !m_lg);
        if (if_req && d_req && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
        m_we   = m_d && d_we;
        m_addr = m_d ? d_addr : if_addr;
        m_wd   = d_wdata;
        m_lg   = m_d;
        m_left = 2;
      end
    end else begin
      m_left = m_left - 1;
    end
  endtask

  task automatic compare_all();
    e_if_valid = (m_left == 1) && !m_d;
    e_d_valid  = (m_left == 1) && m_d;
    check("mem_re", 64'(mem_re), 64'((m_left == 2) && !m_we));
    check("mem_we", 64'(mem_we), 64'((m_left == 2) && m_we));
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    if (m_left == 2 && m_we) check("mem_wd", 64'(mem_wd), 64'(m_wd));
    check("if_valid", 64'(if_valid), 64'(e_if_valid));
    check("d_valid", 64'(d_valid), 64'(e_d_valid));
    if (e_if_valid) check("if_rdata", 64'(if_rdata), 64'(ref_mem[m_addr[9:2]]));
    if (e_d_valid && !m_we) check("d_rdata", 64'(d_rdata), 64'(ref_mem[m_addr[9:2]]));
    check("stall", 64'(stall), 64'((if_req && !e_if_valid) || (d_req && !e_d_valid)));
    check("conflicts", 64'(conflicts), 64'(m_conf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [9:0] rand_addr();
    logic [9:0] a;
    a = 10'($urandom_range(0, 31)) << 2;
    return a;
  endfunction

  task automatic drive_random();
    reset = ($urandom_range(0, 299) == 0);
    if (!if_req || e_if_valid) begin
      if_req  = ($urandom_range(0, 3) != 0);
      if_addr = rand_addr();
    end else if ($urandom_range(0, 3) == 0) begin
      if_addr = rand_addr();
    end
    if (!d_req || e_d_valid) begin
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = ($urandom_range(0, 1) == 1);
      d_addr  = rand_addr();
      d_wdata = $urandom;
    end else if ($urandom_range(0, 3) == 0) begin
      d_addr  = rand_addr();
      d_wdata = $urandom;
    end
  endtask

  initial begin
    int cnt;
    int got;
    int n_gr;
    logic [3:0] order;

    for (int unsigned i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset = 1'b1;
    tick();
    tick();
    ram_init = 1'b0;
    check("reset_conflicts", 64'(conflicts), 64'(0));
    check("reset_mem_re", 64'(mem_re), 64'(0));

    // Single fetch
    reset = 1'b0; if_req = 1'b1; if_addr = 10'h010;
    #1 check("fetch_stall_c1", 64'(stall), 64'(1));
    cnt = 0;
    tick(); check("fetch_re_c2", 64'(mem_re), 64'(1)); check("fetch_stall_c2", 64'(stall), 64'(1));
    cnt += int'(mem_re);
    tick(); check("fetch_valid_c3", 64'(if_valid), 64'(1));
    check("fetch_data", 64'(if_rdata), 64'(32'h00500093));
    check("fetch_stall_c3", 64'(stall), 64'(0));
    cnt += int'(mem_re);
    if_req = 1'b0;
    tick(); cnt += int'(mem_re);
    check("fetch_re_count", 64'(cnt), 64'(1));

    // Store then load to the same address
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h04C; d_wdata = 32'hDEADBEEF;
    cnt = 0; got = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(mem_we);
      if (d_valid) begin
        if (d_we) d_we = 1'b0;
        else begin
          check("load_after_store", 64'(d_rdata), 64'(32'hDEADBEEF));
          got++;
          d_req = 1'b0;
        end
      end
    end
    check("store_we_pulses", 64'(cnt), 64'(1));
    check("load_completions", 64'(got), 64'(1));

    // Address change after grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h004;
    tick(); check("addr_hold_access", 64'(mem_addr), 64'(10'h004));
    d_addr = 10'h008;
    tick(); check("addr_hold_resp", 64'(mem_addr), 64'(10'h004));
    check("addr_chg_valid", 64'(d_valid), 64'(1));
    check("addr_chg_data", 64'(d_rdata), 64'(ref_mem[1]));
    d_req = 1'b0;
    tick();

    // Contention from reset
    reset = 1'b1; tick(); reset = 1'b0;
    if_req = 1'b1; if_addr = 10'h010; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    order = '0; n_gr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (d_valid)  begin order = {order[2:0], 1'b1}; n_gr++; end
      if (if_valid) begin order = {order[2:0], 1'b0}; n_gr++; end
      if (i == 4) check("conflicts_after_two", 64'(conflicts), 64'(2));
    end
    if_req = 1'b0; d_req = 1'b0;
    check("grant_order", 64'(order), 64'(4'b1010));
    check("grant_count", 64'(n_gr), 64'(4));
    check("conflicts_after_four", 64'(conflicts), 64'(4));

    // Reset during RESP of a fetch
    tick();
    if_req = 1'b1; if_addr = 10'h010;
    tick(); tick();
    check("pre_reset_valid", 64'(if_valid), 64'(1));
    reset = 1'b1; if_req = 1'b0;
    tick();
    check("rst_if_valid", 64'(if_valid), 64'(0));
    check("rst_d_valid", 64'(d_valid), 64'(0));
    check("rst_conflicts", 64'(conflicts), 64'(0));
    check("rst_mem_re", 64'(mem_re), 64'(0));
    reset = 1'b0;
    tick(); check("rst_idle_mem_re", 64'(mem_re), 64'(0));

    // Counter saturation
    force dut.conflicts = 16'hFFFE;
    #1 release dut.conflicts;
    m_conf = 16'hFFFE;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("sat_reach", 64'(conflicts), 64'(16'hFFFF));
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold", 64'(conflicts), 64'(16'hFFFF));
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
